// File: rtl/pong_pkg.sv
// Shared screen geometry, colours, coordinate widths and FSM encoding for the pong renderer.
// PONG_CENTER_NET_EN (see pong_draw_engine.sv) makes S_NET reachable.
package pong_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ERASE_L = 4'd1,
      S_ERASE_R = 4'd2,
      S_ERASE_B = 4'd3,
      S_DRAW_L  = 4'd4,
      S_DRAW_R  = 4'd5,
      S_DRAW_B  = 4'd6,
      S_NET     = 4'd7,
      S_FIN     = 4'd8
   } state_e;

   function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v, input logic [X_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v, input logic [Y_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/pong_draw_engine_rect_scan.sv
// Row-major rectangle walker: load latches origin/extent, step advances one pixel.
// The current coordinate registers are the pixel outputs themselves.
module rect_scan
   import pong_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [X_W-1:0] org_x,
   input  logic [Y_W-1:0] org_y,
   input  logic [X_W-1:0] width,
   input  logic [Y_W-1:0] height,
   output logic [X_W-1:0] px,
   output logic [Y_W-1:0] py,
   output logic           last
);

   logic [X_W-1:0] px_q, px_d, x0_q, x0_d, x1_q, x1_d;
   logic [Y_W-1:0] py_q, py_d, y1_q, y1_d;

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      x0_d = x0_q;
      x1_d = x1_q;
      y1_d = y1_q;
      if (load) begin
         px_d = org_x;
         py_d = org_y;
         x0_d = org_x;
         x1_d = org_x + width - X_W'(1);
         y1_d = org_y + height - Y_W'(1);
      end else if (step) begin
         if (px_q == x1_q) begin
            px_d = x0_q;
            py_d = py_q + Y_W'(1);
         end else begin
            px_d = px_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q <= '0;
         py_q <= '0;
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
         x0_q <= x0_d;
         x1_q <= x1_d;
         y1_q <= y1_d;
      end
   end

   assign px   = px_q;
   assign py   = py_q;
   assign last = (px_q == x1_q) && (py_q == y1_q);

endmodule

// File: rtl/pong_draw_engine.sv
// Per-frame sprite renderer feeding the 160x120 VGA adapter: erase old objects, draw new ones.
// Optional `PONG_CENTER_NET_EN adds a dashed centre net drawn after the ball.
module pong_draw_engine
   import pong_pkg::*;
#(
   parameter int         PADDLE_W  = 2,
   parameter int         PADDLE_H  = 16,
   parameter int         BALL_SZ   = 2,
   parameter int         LEFT_X    = 4,
   parameter int         RIGHT_X   = 154,
   parameter logic [2:0] FG_COLOUR = WHITE,
   parameter logic [2:0] BG_COLOUR = BLACK
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   input  logic [Y_W-1:0] lpad_y,
   input  logic [Y_W-1:0] rpad_y,
   input  logic [X_W-1:0] ball_x,
   input  logic [Y_W-1:0] ball_y,
   output logic           busy,
   output logic           done,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic [2:0]     colour,
   output logic           plot
);

   localparam logic [Y_W-1:0] PAD_Y_MAX  = Y_W'(SCREEN_H - PADDLE_H);
   localparam logic [X_W-1:0] BALL_X_MAX = X_W'(SCREEN_W - BALL_SZ);
   localparam logic [Y_W-1:0] BALL_Y_MAX = Y_W'(SCREEN_H - BALL_SZ);
   localparam logic [X_W-1:0] NET_X      = X_W'(SCREEN_W / 2 - 1);

   state_e         state_q, state_d, nxt;
   logic           busy_q, busy_d, done_q, done_d, plot_q, plot_d, old_valid_q, old_valid_d;
   logic [2:0]     colour_q, colour_d;
   logic [Y_W-1:0] old_lpad_q, old_lpad_d, old_rpad_q, old_rpad_d, old_by_q, old_by_d;
   logic [Y_W-1:0] new_lpad_q, new_lpad_d, new_rpad_q, new_rpad_d, new_by_q, new_by_d;
   logic [X_W-1:0] old_bx_q, old_bx_d, new_bx_q, new_bx_d;

   logic           load, step, last;
   logic [X_W-1:0] org_x, rect_w, scan_px;
   logic [Y_W-1:0] org_y, rect_h, scan_py;

`ifdef PONG_CENTER_NET_EN
   logic [Y_W-1:0] py_inc;
   assign py_inc = scan_py + Y_W'(1);
`endif

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      plot_d      = plot_q;
      colour_d    = colour_q;
      old_valid_d = old_valid_q;
      old_lpad_d  = old_lpad_q;
      old_rpad_d  = old_rpad_q;
      old_bx_d    = old_bx_q;
      old_by_d    = old_by_q;
      new_lpad_d  = new_lpad_q;
      new_rpad_d  = new_rpad_q;
      new_bx_d    = new_bx_q;
      new_by_d    = new_by_q;
      load        = 1'b0;
      step        = 1'b0;
      org_x       = '0;
      org_y       = '0;
      rect_w      = '0;
      rect_h      = '0;

      case (state_q)
         S_ERASE_L: nxt = S_ERASE_R;
         S_ERASE_R: nxt = S_ERASE_B;
         S_ERASE_B: nxt = S_DRAW_L;
         S_DRAW_L:  nxt = S_DRAW_R;
         S_DRAW_R:  nxt = S_DRAW_B;
`ifdef PONG_CENTER_NET_EN
         S_DRAW_B:  nxt = S_NET;
`else
         S_DRAW_B:  nxt = S_FIN;
`endif
         default:   nxt = S_FIN;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d     = 1'b1;
               new_lpad_d = clamp_y(lpad_y, PAD_Y_MAX);
               new_rpad_d = clamp_y(rpad_y, PAD_Y_MAX);
               new_bx_d   = clamp_x(ball_x, BALL_X_MAX);
               new_by_d   = clamp_y(ball_y, BALL_Y_MAX);
               state_d    = old_valid_q ? S_ERASE_L : S_DRAW_L;
               load       = 1'b1;
            end
         end
         S_FIN: begin
            done_d      = 1'b0;
            busy_d      = 1'b0;
            old_valid_d = 1'b1;
            old_lpad_d  = new_lpad_q;
            old_rpad_d  = new_rpad_q;
            old_bx_d    = new_bx_q;
            old_by_d    = new_by_q;
            state_d     = S_IDLE;
         end
         default: begin
            if (last) begin
               state_d = nxt;
               if (nxt == S_FIN) begin
                  plot_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  load = 1'b1;
               end
            end else begin
               step = 1'b1;
`ifdef PONG_CENTER_NET_EN
               // Net is dashed: only rows with bit 2 clear are written.
               if (state_q == S_NET) plot_d = ~py_inc[2];
`endif
            end
         end
      endcase

      if (load) begin
         plot_d   = 1'b1;
         colour_d = (state_d inside {S_ERASE_L, S_ERASE_R, S_ERASE_B}) ? BG_COLOUR : FG_COLOUR;
      end

      // Origin of the rectangle being entered; new_*_d covers the load on the start edge.
      case (state_d)
         S_ERASE_L: begin org_x = X_W'(LEFT_X);  org_y = old_lpad_q; rect_w = X_W'(PADDLE_W); rect_h = Y_W'(PADDLE_H); end
         S_ERASE_R: begin org_x = X_W'(RIGHT_X); org_y = old_rpad_q; rect_w = X_W'(PADDLE_W); rect_h = Y_W'(PADDLE_H); end
         S_ERASE_B: begin org_x = old_bx_q;      org_y = old_by_q;   rect_w = X_W'(BALL_SZ);  rect_h = Y_W'(BALL_SZ);  end
         S_DRAW_L:  begin org_x = X_W'(LEFT_X);  org_y = new_lpad_d; rect_w = X_W'(PADDLE_W); rect_h = Y_W'(PADDLE_H); end
         S_DRAW_R:  begin org_x = X_W'(RIGHT_X); org_y = new_rpad_d; rect_w = X_W'(PADDLE_W); rect_h = Y_W'(PADDLE_H); end
         S_DRAW_B:  begin org_x = new_bx_d;      org_y = new_by_d;   rect_w = X_W'(BALL_SZ);  rect_h = Y_W'(BALL_SZ);  end
         S_NET:     begin org_x = NET_X;         org_y = '0;         rect_w = X_W'(1);        rect_h = Y_W'(SCREEN_H); end
         default:   ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         plot_q      <= 1'b0;
         colour_q    <= '0;
         old_valid_q <= 1'b0;
         old_lpad_q  <= '0;
         old_rpad_q  <= '0;
         old_bx_q    <= '0;
         old_by_q    <= '0;
         new_lpad_q  <= '0;
         new_rpad_q  <= '0;
         new_bx_q    <= '0;
         new_by_q    <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         plot_q      <= plot_d;
         colour_q    <= colour_d;
         old_valid_q <= old_valid_d;
         old_lpad_q  <= old_lpad_d;
         old_rpad_q  <= old_rpad_d;
         old_bx_q    <= old_bx_d;
         old_by_q    <= old_by_d;
         new_lpad_q  <= new_lpad_d;
         new_rpad_q  <= new_rpad_d;
         new_bx_q    <= new_bx_d;
         new_by_q    <= new_by_d;
      end
   end

   rect_scan u_scan (
      .clk    (clock),
      .rst_n  (resetn),
      .load   (load),
      .step   (step),
      .org_x  (org_x),
      .org_y  (org_y),
      .width  (rect_w),
      .height (rect_h),
      .px     (scan_px),
      .py     (scan_py),
      .last   (last)
   );

   assign busy   = busy_q;
   assign done   = done_q;
   assign plot   = plot_q;
   assign colour = colour_q;
   assign x      = scan_px;
   assign y      = scan_py;

endmodule
